afpm_result_serializer: RTL and testbench

Transmit-side byte serializer for the logarithmic FP16 multiplier tile. It accepts 16-bit results over a valid/ready handshake and buffers them in a small FIFO. It then streams each result onto the 8-bit dedicated output lane as two beats, low byte first, which is the same byte order the tile uses to receive its operands. Downstream pacing is controlled by `out_ready`; tied high, the block emits one byte per cycle.

---
 rtl/afpm_result_serializer.sv | 125 ++++++++++++
 tb/tb_afpm_result_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/afpm_result_serializer.sv
// Transmit-side serializer: buffers 16-bit results in a small FIFO and streams
// each one onto the 8-bit output lane as two beats, low byte first.
module afpm_result_serializer #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_data,
  output logic [7:0]                 out_byte,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [7:0]                 tx_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [15:0]        word_q, word_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               push, pop;

  // No push-through: a full FIFO refuses input even when a pop is under way.
  assign in_ready = (level_q < DEPTH_L);
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr_q];
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (out_ready) state_d = S_HI;
      end
      S_HI: begin
        if (out_ready) begin
          tx_d = tx_q + 8'd1;
          // Reload straight from the FIFO so back-to-back words have no bubble.
          if (level_q != '0) begin
            pop     = 1'b1;
            word_d  = mem_q[rd_ptr_q];
            state_d = S_LO;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Output registers are loaded from the next state so every output is a flop.
    out_valid_d = (state_d != S_IDLE);
    out_last_d  = (state_d == S_HI);
    out_byte_d  = 8'h00;
    if (state_d == S_LO)      out_byte_d = word_d[7:0];
    else if (state_d == S_HI) out_byte_d = word_d[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tx_q        <= 8'h00;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      tx_q        <= tx_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset; the cleared pointers and level make stale words unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    word_q <= word_d;
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign level     = level_q;
  assign tx_count  = tx_q;

endmodule

// File: tb/tb_afpm_result_serializer.sv
// Scoreboard bench for afpm_result_serializer: accepted words expand into an
// expected byte queue that a free-running monitor drains as beats are accepted.
module tb_afpm_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  level;
  logic [7:0]  tx_count;

  afpm_result_serializer #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .level     (level),
    .tx_count  (tx_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         model_tx = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. what the next rising edge will see.
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] pb;
    logic       pl;
    logic [8:0] e;
    prev_stall = 1'b0;
    pb = 8'h00;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_tx   = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_byte", out_byte, pb);
          check("stall_last", out_last, pl);
          check("stall_valid", out_valid, 1);
        end
        check("tx_count", tx_count, model_tx);
        if (!out_valid) begin
          check("idle_byte", out_byte, 0);
          check("idle_last", out_last, 0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", out_byte);
          end else begin
            e = exp_q.pop_front();
            check("beat_byte", out_byte, e[7:0]);
            check("beat_last", out_last, e[8]);
            if (e[8]) model_tx = (model_tx + 1) % 256;
          end
        end
        prev_stall = out_valid && !out_ready;
        pb = out_byte;
        pl = out_last;
      end
    end
  end

  // One clock cycle of stimulus; returns whether the word was taken at the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic r, output logic taken);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    taken = v && in_ready && !rst;
    @(posedge clk);
    if (taken) begin
      exp_q.push_back({1'b0, d[7:0]});
      exp_q.push_back({1'b1, d[15:8]});
    end
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input logic r);
    logic t;
    bit   ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step(1'b1, d, r, t);
      if (t) ok = 1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_taken required=taken data=%h", d);
    end
  endtask

  task automatic drain();
    logic t;
    bit   ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(1'b0, 16'h0000, 1'b1, t);
      if (!out_valid && level == 2'd0) ok = 1;
    end
    check("drain_done", ok, 1);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    logic t;
    rst = 1'b1;
    step(1'b0, 16'h0000, 1'b1, t);
    rst = 1'b0;
  endtask

  initial begin : driver
    logic        t;
    logic [15:0] w [3];
    int          idx;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b0;
    step(1'b0, 16'h0000, 1'b0, t);
    step(1'b0, 16'h0000, 1'b0, t);
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_byte", out_byte, 0);
    check("rst_last", out_last, 0);
    check("rst_level", level, 0);
    check("rst_tx", tx_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Single word latency
    step(1'b1, 16'h4480, 1'b1, t);
    check("single_taken", t, 1);
    step(1'b0, 16'h0000, 1'b1, t);
    check("single_lo_valid", out_valid, 1);
    check("single_lo_byte", out_byte, 8'h80);
    check("single_lo_last", out_last, 0);
    step(1'b0, 16'h0000, 1'b1, t);
    check("single_hi_byte", out_byte, 8'h44);
    check("single_hi_last", out_last, 1);
    step(1'b0, 16'h0000, 1'b1, t);
    check("single_done_valid", out_valid, 0);
    check("single_tx", tx_count, 1);
    drain();

    // Back-to-back stream with no gaps
    w[0] = 16'h0000; w[1] = 16'h3E00; w[2] = 16'h4200;
    idx = 0;
    step(1'b1, w[0], 1'b1, t);
    check("b2b_first_taken", t, 1);
    idx = 1;
    for (int i = 0; i < 6; i++) begin
      step(idx < 3, (idx < 3) ? w[idx] : 16'h0000, 1'b1, t);
      if (t) idx++;
      check("b2b_continuous_valid", out_valid, 1);
      check("b2b_last_pattern", out_last, (i % 2));
    end
    check("b2b_all_pushed", idx, 3);
    step(1'b0, 16'h0000, 1'b1, t);
    check("b2b_end_valid", out_valid, 0);
    drain();

    // Backpressure during the high byte, FIFO fills
    push_word(16'hABCD, 1'b1);
    step(1'b0, 16'h0000, 1'b1, t);
    check("bp_lo_byte", out_byte, 8'hCD);
    step(1'b0, 16'h0000, 1'b1, t);
    check("bp_hi_byte", out_byte, 8'hAB);
    step(1'b1, 16'h1111, 1'b0, t);
    check("bp_push1", t, 1);
    step(1'b1, 16'h2222, 1'b0, t);
    check("bp_push2", t, 1);
    check("bp_level_full", level, 2);
    check("bp_in_ready", in_ready, 0);
    step(1'b1, 16'h3333, 1'b0, t);
    check("bp_push3_refused", t, 0);
    step(1'b0, 16'h0000, 1'b0, t);
    step(1'b0, 16'h0000, 1'b0, t);
    check("bp_hold_byte", out_byte, 8'hAB);
    check("bp_hold_last", out_last, 1);
    check("bp_hold_valid", out_valid, 1);
    drain();

    // Simultaneous push and pop at the SEND_HI -> SEND_LO reload
    push_word(16'hA5A5, 1'b0);
    step(1'b0, 16'h0000, 1'b0, t);
    push_word(16'hC33C, 1'b0);
    step(1'b0, 16'h0000, 1'b1, t);
    check("sim_pre_level", level, 1);
    check("sim_pre_last", out_last, 1);
    step(1'b1, 16'h5555, 1'b1, t);
    check("sim_push_taken", t, 1);
    check("sim_level_held", level, 1);
    check("sim_next_byte", out_byte, 8'h3C);
    check("sim_next_last", out_last, 0);
    drain();

    // Reset in the middle of a word with one word buffered
    step(1'b1, 16'h4480, 1'b1, t);
    step(1'b1, 16'h1234, 1'b1, t);
    check("rm_lo_byte", out_byte, 8'h80);
    check("rm_level", level, 1);
    do_reset();
    check("rm_valid", out_valid, 0);
    check("rm_level_clr", level, 0);
    check("rm_tx_clr", tx_count, 0);
    check("rm_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0000, 1'b1, t);
      check("rm_quiet", out_valid, 0);
    end

    // Transmit counter wrap
    for (int i = 0; i < 255; i++) push_word(16'($urandom), 1'b1);
    drain();
    check("wrap_255", tx_count, 255);
    push_word(16'h7C00, 1'b1);
    drain();
    check("wrap_0", tx_count, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) != 0, t);
      rst = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
